mc_control_unit: RTL and testbench
==================================

# mc_control_unit

Multicycle control finite-state machine (FSM) that sequences each instruction through the fetch, decode, execute, memory and write-back phases (IF/ID/EXE/MEM/WB). It drives every datapath enable and select, including the 3-bit `ALUOp` consumed by the ALU, and it takes the ALU `zero` flag back for branch resolution. It sits at the top of the multicycle CPU. It reads `opcode` from the instruction register (IR) and fans its control lines out to the program counter (PC), instruction memory, register file, ALU muxes and data memory.

## Interface
- No parameters; all encodings are fixed in the shared package.
- `CLK`  in  1  system clock, rising edge.
- `RST`  in  1  reset: synchronous and active-low.
- `opcode`  in  6  `IR[31:26]`; stable from the cycle after IF until the next IF.
- `zero`  in  1  ALU zero flag; valid in EXE.
- `state`  out  3  current state, for debug/testbench.
- `PCWre`  out  1  PC write enable.
- `PCSrc`  out  2  next-PC select: 00 = PC+4, 01 = branch target, 10 = jump target.
- `IRWre`  out  1  instruction register load.
- `InsMemRW`  out  1  instruction memory read enable.
- `ExtSel`  out  1  immediate extension: 1 = sign-extend, 0 = zero-extend.
- `ALUSrcB`  out  1  ALU B operand: 0 = register rt, 1 = extended immediate.
- `ALUOp`  out  3  ALU function: 000 = add, 001 = sub, 101 = or.
- `RegDst`  out  1  destination register: 0 = rt, 1 = rd.
- `RegWre`  out  1  register file write enable.
- `MemToReg`  out  1  write-back source: 0 = ALU result, 1 = memory data.
- `mRD`, `mWR`  out  1 each  data memory read / write enable.

## Operation
- Opcodes:
  - add = 000000, sub = 000001, ori = 010000
  - sw = 110000, lw = 110001, beq = 110100
  - j = 111000, halt = 111111
  - every other value is a nop.
- States:
  - IF = 000, ID = 001, EXE = 010, MEM = 011, WB = 100, HALT = 101.
  - Codes 110 and 111 are illegal and go to IF on the next edge.
- Transitions:
  - IF → ID.
  - ID → IF for j or nop; ID → HALT for halt; ID → EXE otherwise.
  - EXE → IF for beq; EXE → MEM for lw/sw; EXE → WB for add/sub/ori.
  - MEM → WB for lw; MEM → IF for sw.
  - WB → IF.
  - HALT → HALT until reset.
- Outputs are combinational from (`state`, `opcode`, `zero`). Any signal not listed is 0.
  - IF: `IRWre` = 1, `InsMemRW` = 1.
  - ID, j: `PCWre` = 1, `PCSrc` = 10.
  - ID, nop: `PCWre` = 1, `PCSrc` = 00.
  - EXE: `ALUOp` from the decode sub-module. `ALUSrcB` = 1 for ori/lw/sw. `ExtSel` = 0 for ori, 1 otherwise.
  - EXE, beq: `ALUOp` = 001, `PCWre` = 1, `PCSrc` = 01 if `zero` else 00.
  - MEM: lw gives `mRD` = 1; sw gives `mWR` = 1, `PCWre` = 1, `PCSrc` = 00.
  - WB: `RegWre` = 1, `PCWre` = 1, `PCSrc` = 00. `RegDst` = 1 for add/sub. `MemToReg` = 1 for lw.
  - HALT: all enables 0.
- `ALUOp` is 000 in every state other than EXE, so the ALU always sees a defined code.
- Exactly one `PCWre` pulse per completed instruction. It occurs in the instruction's final state.

## Timing
- Reset: while `RST` = 0 at a rising edge, the next `state` = IF. While `RST` is low, every output is forced to 0, including `IRWre` and `InsMemRW`.
  - The first fetch happens in the first cycle with `RST` = 1.
- Cycles per instruction, IF through final state:
  - j/nop = 2, beq = 3, add/sub/ori/sw = 4, lw = 5, halt = 2, then stuck in HALT.
- `zero` is sampled combinationally in EXE only. Glitches outside EXE have no effect.
- Reset asserted mid-instruction (any state, including HALT): the next state is IF. No partial write may follow: `RegWre`, `mWR` and `PCWre` are 0 from the reset edge onward.
- `opcode` changes outside IF are a datapath error. The FSM follows the current value without latching it.

## Structure
- Package `mc_cpu_pkg` holds:
  - state encodings;
  - opcode constants;
  - `ALUOp` constants (`ALU_ADD` = 000, `ALU_SUB` = 001, `ALU_OR` = 101);
  - `PCSrc` constants.
- The ALU imports the same `ALUOp` constants.
- Sub-module `alu_op_decode` is purely combinational: `opcode` → `ALUOp`.
  - add/lw/sw → 000
  - sub/beq → 001
  - ori → 101
  - others → 000
- The top level holds the state register, next-state logic and output decode.

## Test plan
- Reset: hold `RST` = 0 for 3 cycles in an arbitrary state → `state` = 000 and all outputs 0. Release → `IRWre` = 1 in that cycle, `state` = 001 next cycle.
- add (000000): states IF, ID, EXE, WB. `ALUOp` = 000 in EXE. In WB, `RegWre` = 1, `RegDst` = 1 and `PCWre` = 1. Exactly one `PCWre` pulse in 4 cycles.
- lw (110001): 5-cycle sequence.
  - EXE: `ALUSrcB` = 1, `ExtSel` = 1.
  - MEM: `mRD` = 1, `mWR` = 0.
  - WB: `MemToReg` = 1.
- sw (110000): ends after MEM with `mWR` = 1 and `PCWre` = 1; no `RegWre` ever.
- beq (110100): with `zero` = 1 → EXE has `ALUOp` = 001 and `PCSrc` = 01; with `zero` = 0 → `PCSrc` = 00; back in IF after 3 cycles.
- j (111000): `PCSrc` = 10 with `PCWre` in ID. Unknown opcode 101010: `PCSrc` = 00 in ID. halt (111111): `state` = 101 for 10+ cycles with all outputs 0, until `RST` = 0 returns it to 000.

Source files
------------

// File: rtl/mc_cpu_pkg.sv
// Shared encodings for the multicycle CPU: FSM states, opcodes, ALU functions
// and next-PC selects. The ALU and the control unit both import this package.
package mc_cpu_pkg;

    typedef enum logic [2:0] {
        S_IF   = 3'b000,
        S_ID   = 3'b001,
        S_EXE  = 3'b010,
        S_MEM  = 3'b011,
        S_WB   = 3'b100,
        S_HALT = 3'b101
    } state_t;

    localparam logic [5:0] OP_ADD  = 6'b000000;
    localparam logic [5:0] OP_SUB  = 6'b000001;
    localparam logic [5:0] OP_ORI  = 6'b010000;
    localparam logic [5:0] OP_SW   = 6'b110000;
    localparam logic [5:0] OP_LW   = 6'b110001;
    localparam logic [5:0] OP_BEQ  = 6'b110100;
    localparam logic [5:0] OP_J    = 6'b111000;
    localparam logic [5:0] OP_HALT = 6'b111111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_OR  = 3'b101;

    localparam logic [1:0] PC_NEXT   = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    // Opcodes that take the EXE path; anything else is j, halt or a nop.
    function automatic logic is_exec_op(input logic [5:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_ORI) ||
               (op == OP_SW)  || (op == OP_LW)  || (op == OP_BEQ);
    endfunction

endpackage

// File: rtl/mc_control_unit_alu_op_decode.sv
// Pure opcode -> ALU function decode used while the FSM is in EXE.
module alu_op_decode
    import mc_cpu_pkg::*;
(
    input  logic [5:0] opcode,
    output logic [2:0] alu_op
);

    // Map each opcode onto the ALU function it needs; default to add.
    always_comb begin
        alu_op = ALU_ADD;
        case (opcode)
            OP_SUB, OP_BEQ: alu_op = ALU_SUB;
            OP_ORI:         alu_op = ALU_OR;
            default:        alu_op = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_control_unit.sv
// Multicycle control FSM: walks each instruction through IF/ID/EXE/MEM/WB and
// drives all datapath enables and selects from (state, opcode, zero).
module mc_control_unit
    import mc_cpu_pkg::*;
(
    input  logic       CLK,
    input  logic       RST,
    input  logic [5:0] opcode,
    input  logic       zero,
    output logic [2:0] state,
    output logic       PCWre,
    output logic [1:0] PCSrc,
    output logic       IRWre,
    output logic       InsMemRW,
    output logic       ExtSel,
    output logic       ALUSrcB,
    output logic [2:0] ALUOp,
    output logic       RegDst,
    output logic       RegWre,
    output logic       MemToReg,
    output logic       mRD,
    output logic       mWR
);

    state_t     r_state;
    state_t     w_next;
    logic [2:0] w_alu_op;

    alu_op_decode u_alu_op_decode (
        .opcode (opcode),
        .alu_op (w_alu_op)
    );

    assign state = r_state;

    // State register; synchronous active-low reset returns to fetch.
    always_ff @(posedge CLK) begin
        if (!RST) r_state <= S_IF;
        else      r_state <= w_next;
    end

    // Next-state logic; the unused codes 110/111 recover to IF.
    always_comb begin
        w_next = S_IF;
        case (r_state)
            S_IF:  w_next = S_ID;
            S_ID: begin
                if (opcode == OP_HALT)       w_next = S_HALT;
                else if (is_exec_op(opcode)) w_next = S_EXE;
                else                         w_next = S_IF;
            end
            S_EXE: begin
                if (opcode == OP_BEQ)                         w_next = S_IF;
                else if (opcode == OP_LW || opcode == OP_SW)  w_next = S_MEM;
                else                                          w_next = S_WB;
            end
            S_MEM:  w_next = (opcode == OP_LW) ? S_WB : S_IF;
            S_WB:   w_next = S_IF;
            S_HALT: w_next = S_HALT;
            default: w_next = S_IF;
        endcase
    end

    // Output decode; everything is held low while reset is asserted so no
    // partial write can leak out of an interrupted instruction.
    always_comb begin
        PCWre    = 1'b0;
        PCSrc    = PC_NEXT;
        IRWre    = 1'b0;
        InsMemRW = 1'b0;
        ExtSel   = 1'b0;
        ALUSrcB  = 1'b0;
        ALUOp    = ALU_ADD;
        RegDst   = 1'b0;
        RegWre   = 1'b0;
        MemToReg = 1'b0;
        mRD      = 1'b0;
        mWR      = 1'b0;
        if (RST) begin
            case (r_state)
                S_IF: begin
                    IRWre    = 1'b1;
                    InsMemRW = 1'b1;
                end
                S_ID: begin
                    if (opcode == OP_J) begin
                        PCWre = 1'b1;
                        PCSrc = PC_JUMP;
                    end else if (opcode != OP_HALT && !is_exec_op(opcode)) begin
                        PCWre = 1'b1;
                        PCSrc = PC_NEXT;
                    end
                end
                S_EXE: begin
                    ALUOp   = w_alu_op;
                    ALUSrcB = (opcode == OP_ORI) || (opcode == OP_LW) || (opcode == OP_SW);
                    ExtSel  = (opcode != OP_ORI);
                    if (opcode == OP_BEQ) begin
                        PCWre = 1'b1;
                        PCSrc = zero ? PC_BRANCH : PC_NEXT;
                    end
                end
                S_MEM: begin
                    if (opcode == OP_LW) begin
                        mRD = 1'b1;
                    end else begin
                        mWR   = 1'b1;
                        PCWre = 1'b1;
                        PCSrc = PC_NEXT;
                    end
                end
                S_WB: begin
                    RegWre   = 1'b1;
                    PCWre    = 1'b1;
                    PCSrc    = PC_NEXT;
                    RegDst   = (opcode == OP_ADD) || (opcode == OP_SUB);
                    MemToReg = (opcode == OP_LW);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mc_control_unit.sv
// Directed bench for mc_control_unit: steps each opcode through its state
// sequence and checks state plus the full control vector every cycle.
module tb_mc_control_unit;

    logic       CLK = 1'b0;
    logic       RST;
    logic [5:0] opcode;
    logic       zero;
    logic [2:0] state;
    logic       PCWre, IRWre, InsMemRW, ExtSel, ALUSrcB;
    logic       RegDst, RegWre, MemToReg, mRD, mWR;
    logic [1:0] PCSrc;
    logic [2:0] ALUOp;
    logic [14:0] outs;

    int npass = 0;
    int ntotal = 0;

    mc_control_unit dut (
        .CLK(CLK), .RST(RST), .opcode(opcode), .zero(zero), .state(state),
        .PCWre(PCWre), .PCSrc(PCSrc), .IRWre(IRWre), .InsMemRW(InsMemRW),
        .ExtSel(ExtSel), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .RegDst(RegDst),
        .RegWre(RegWre), .MemToReg(MemToReg), .mRD(mRD), .mWR(mWR)
    );

    always #5 CLK = ~CLK;

    assign outs = {PCWre, PCSrc, IRWre, InsMemRW, ExtSel, ALUSrcB, ALUOp,
                   RegDst, RegWre, MemToReg, mRD, mWR};

    function automatic logic [14:0] mk(
        input logic pcw, input logic [1:0] pcs, input logic irw, input logic ins,
        input logic ext, input logic bsrc, input logic [2:0] aop, input logic rdst,
        input logic rwe, input logic m2r, input logic rd, input logic wr);
        return {pcw, pcs, irw, ins, ext, bsrc, aop, rdst, rwe, m2r, rd, wr};
    endfunction

    localparam logic [14:0] O_ZERO     = 15'd0;
    localparam logic [14:0] O_IF       = mk(0, 2'b00, 1, 1, 0, 0, 3'b000, 0, 0, 0, 0, 0);
    localparam logic [14:0] O_ID_J     = mk(1, 2'b10, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0);
    localparam logic [14:0] O_ID_NOP   = mk(1, 2'b00, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0);
    localparam logic [14:0] O_EXE_ADD  = mk(0, 2'b00, 0, 0, 1, 0, 3'b000, 0, 0, 0, 0, 0);
    localparam logic [14:0] O_EXE_SUB  = mk(0, 2'b00, 0, 0, 1, 0, 3'b001, 0, 0, 0, 0, 0);
    localparam logic [14:0] O_EXE_ORI  = mk(0, 2'b00, 0, 0, 0, 1, 3'b101, 0, 0, 0, 0, 0);
    localparam logic [14:0] O_EXE_LS   = mk(0, 2'b00, 0, 0, 1, 1, 3'b000, 0, 0, 0, 0, 0);
    localparam logic [14:0] O_BEQ_T    = mk(1, 2'b01, 0, 0, 1, 0, 3'b001, 0, 0, 0, 0, 0);
    localparam logic [14:0] O_BEQ_N    = mk(1, 2'b00, 0, 0, 1, 0, 3'b001, 0, 0, 0, 0, 0);
    localparam logic [14:0] O_MEM_LW   = mk(0, 2'b00, 0, 0, 0, 0, 3'b000, 0, 0, 0, 1, 0);
    localparam logic [14:0] O_MEM_SW   = mk(1, 2'b00, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 1);
    localparam logic [14:0] O_WB_R     = mk(1, 2'b00, 0, 0, 0, 0, 3'b000, 1, 1, 0, 0, 0);
    localparam logic [14:0] O_WB_I     = mk(1, 2'b00, 0, 0, 0, 0, 3'b000, 0, 1, 0, 0, 0);
    localparam logic [14:0] O_WB_LW    = mk(1, 2'b00, 0, 0, 0, 0, 3'b000, 0, 1, 1, 0, 0);

    localparam logic [2:0] IF = 3'b000, ID = 3'b001, EXE = 3'b010,
                           MEM = 3'b011, WB = 3'b100, HALT = 3'b101;

    // Advance to the next falling edge (state has settled after the rising edge).
    task automatic nxt();
        @(negedge CLK);
    endtask

    task automatic chk(input string tag, input logic [2:0] es, input logic [14:0] eo);
        ntotal++;
        assert (state === es) npass++;
        else $error("FAIL %s state got %b want %b", tag, state, es);
        ntotal++;
        assert (outs === eo) npass++;
        else $error("FAIL %s outs got %b want %b", tag, outs, eo);
    endtask

    initial begin
        RST = 1'b0; opcode = 6'b000000; zero = 1'b0;

        // reset held for 3 cycles
        nxt(); chk("rst0", IF, O_ZERO);
        nxt(); chk("rst1", IF, O_ZERO);
        nxt(); chk("rst2", IF, O_ZERO);
        RST = 1'b1; #1 chk("rel_if", IF, O_IF);

        // add, with a zero glitch outside EXE
        nxt(); chk("add_id", ID, O_ZERO);
        zero = 1'b1; #1 chk("add_id_glitch", ID, O_ZERO);
        nxt(); zero = 1'b0; #1 chk("add_exe", EXE, O_EXE_ADD);
        nxt(); zero = 1'b1; #1 chk("add_wb", WB, O_WB_R);
        nxt(); zero = 1'b0; #1 chk("add_if", IF, O_IF);

        // lw
        opcode = 6'b110001;
        nxt(); chk("lw_id", ID, O_ZERO);
        nxt(); chk("lw_exe", EXE, O_EXE_LS);
        nxt(); chk("lw_mem", MEM, O_MEM_LW);
        nxt(); chk("lw_wb", WB, O_WB_LW);
        nxt(); chk("lw_if", IF, O_IF);

        // sw
        opcode = 6'b110000;
        nxt(); chk("sw_id", ID, O_ZERO);
        nxt(); chk("sw_exe", EXE, O_EXE_LS);
        nxt(); chk("sw_mem", MEM, O_MEM_SW);
        nxt(); chk("sw_if", IF, O_IF);

        // sub
        opcode = 6'b000001;
        nxt(); chk("sub_id", ID, O_ZERO);
        nxt(); chk("sub_exe", EXE, O_EXE_SUB);
        nxt(); chk("sub_wb", WB, O_WB_R);
        nxt(); chk("sub_if", IF, O_IF);

        // ori
        opcode = 6'b010000;
        nxt(); chk("ori_id", ID, O_ZERO);
        nxt(); chk("ori_exe", EXE, O_EXE_ORI);
        nxt(); chk("ori_wb", WB, O_WB_I);
        nxt(); chk("ori_if", IF, O_IF);

        // beq taken, then zero dropping inside EXE changes PCSrc combinationally
        opcode = 6'b110100; zero = 1'b1;
        nxt(); chk("beqt_id", ID, O_ZERO);
        nxt(); chk("beqt_exe", EXE, O_BEQ_T);
        zero = 1'b0; #1 chk("beqt_exe_z0", EXE, O_BEQ_N);
        nxt(); chk("beqt_if", IF, O_IF);

        // beq not taken
        nxt(); chk("beqn_id", ID, O_ZERO);
        nxt(); chk("beqn_exe", EXE, O_BEQ_N);
        nxt(); chk("beqn_if", IF, O_IF);

        // j
        opcode = 6'b111000;
        nxt(); chk("j_id", ID, O_ID_J);
        nxt(); chk("j_if", IF, O_IF);

        // unknown opcode behaves as nop
        opcode = 6'b101010;
        nxt(); chk("nop_id", ID, O_ID_NOP);
        nxt(); chk("nop_if", IF, O_IF);

        // reset in the middle of add: outputs drop at once, back to IF
        opcode = 6'b000000;
        nxt(); chk("mid_id", ID, O_ZERO);
        nxt(); chk("mid_exe", EXE, O_EXE_ADD);
        RST = 1'b0; #1 chk("mid_rst_exe", EXE, O_ZERO);
        nxt(); chk("mid_rst_if", IF, O_ZERO);
        RST = 1'b1; #1 chk("mid_rel_if", IF, O_IF);

        // halt: parks in HALT until reset
        opcode = 6'b111111;
        nxt(); chk("halt_id", ID, O_ZERO);
        for (int i = 0; i < 10; i++) begin
            nxt(); chk($sformatf("halt_%0d", i), HALT, O_ZERO);
        end
        RST = 1'b0; #1 chk("halt_rst", HALT, O_ZERO);
        nxt(); chk("halt_rst_if", IF, O_ZERO);
        RST = 1'b1; #1 chk("halt_rel_if", IF, O_IF);

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
